logic_unit_pipe: RTL and testbench

Parametrised, registered successor to the 32-bit combinational logic unit in the Mini-MIPS execute path. It adds NAND, XNOR and ANDN, plus iterative bit-count operations (POPCNT, CLZ, CTZ) that process CHUNK bits per cycle. A valid/ready handshake on input and output lets the execute stage stall on it. A single output register carries the result and a registered zero flag.

---
 rtl/logic_unit_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_logic_unit_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with single-cycle bitwise ops and iterative
// POPCNT/CLZ/CTZ that consume CHUNK bits per cycle, behind valid/ready.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE,
        ITER
    } state_t;

    typedef enum logic [1:0] {
        OP_POP = 2'd0,
        OP_CLZ = 2'd1,
        OP_CTZ = 2'd2
    } iter_op_t;

    // Number of ones in one chunk.
    function automatic logic [CW-1:0] pop_chunk(input logic [CHUNK-1:0] c);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            n = n + CW'(c[i]);
        end
        return n;
    endfunction

    // Leading zeros of one chunk (CHUNK when the chunk is all zero).
    function automatic logic [CW-1:0] lz_chunk(input logic [CHUNK-1:0] c);
        logic [CW-1:0] n;
        logic          done;
        n    = '0;
        done = 1'b0;
        for (int i = int'(CHUNK) - 1; i >= 0; i--) begin
            if (!done) begin
                if (c[i]) done = 1'b1;
                else      n    = n + CW'(1);
            end
        end
        return n;
    endfunction

    // Trailing zeros of one chunk (CHUNK when the chunk is all zero).
    function automatic logic [CW-1:0] tz_chunk(input logic [CHUNK-1:0] c);
        logic [CW-1:0] n;
        logic          done;
        n    = '0;
        done = 1'b0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            if (!done) begin
                if (c[i]) done = 1'b1;
                else      n    = n + CW'(1);
            end
        end
        return n;
    endfunction

    state_t           state_q, state_n;
    iter_op_t         op_q, op_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [CW-1:0]    acc_q, acc_n;
    logic             found_q, found_n;
    logic [WIDTH-1:0] out_n;
    logic             zero_n;
    logic             out_valid_n;

    logic [WIDTH-1:0] logic_res;
    logic [CHUNK-1:0] chunk_hi;
    logic [CHUNK-1:0] chunk_lo;
    logic [CW-1:0]    acc_step;
    logic             found_step;
    logic             is_iter;
    logic             accept;

    assign in_ready = (state_q == IDLE) && (!out_valid || out_ready) && !rst;
    assign busy     = (state_q == ITER);
    assign accept   = in_valid && in_ready;
    assign is_iter  = (func[3:2] == 2'b10) && (func[1:0] != 2'b11);

    // CLZ shifts the operand left and scans the top chunk; the others shift right.
    assign chunk_hi = a_q[WIDTH-1 -: CHUNK];
    assign chunk_lo = a_q[CHUNK-1:0];

    // Single-cycle bitwise result; unused encodings yield zero.
    always_comb begin
        logic_res = '0;
        case (func)
            4'b0000: logic_res = a & b;
            4'b0001: logic_res = a | b;
            4'b0010: logic_res = a ^ b;
            4'b0011: logic_res = ~(a | b);
            4'b0100: logic_res = ~a;
            4'b0101: logic_res = ~(a & b);
            4'b0110: logic_res = ~(a ^ b);
            4'b0111: logic_res = a & ~b;
            default: logic_res = '0;
        endcase
    end

    // One chunk of accumulation; CLZ/CTZ freeze once a one has been seen.
    always_comb begin
        acc_step   = acc_q;
        found_step = found_q;
        case (op_q)
            OP_POP: acc_step = acc_q + pop_chunk(chunk_lo);
            OP_CLZ: begin
                if (!found_q) begin
                    acc_step   = acc_q + lz_chunk(chunk_hi);
                    found_step = |chunk_hi;
                end
            end
            OP_CTZ: begin
                if (!found_q) begin
                    acc_step   = acc_q + tz_chunk(chunk_lo);
                    found_step = |chunk_lo;
                end
            end
            default: ;
        endcase
    end

    // Next-state, iteration datapath and output-register control.
    always_comb begin
        state_n     = state_q;
        op_n        = op_q;
        a_n         = a_q;
        cnt_n       = cnt_q;
        acc_n       = acc_q;
        found_n     = found_q;
        out_n       = out;
        zero_n      = zero;
        out_valid_n = out_valid && !out_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_iter) begin
                        state_n = ITER;
                        op_n    = iter_op_t'(func[1:0]);
                        a_n     = a;
                        cnt_n   = '0;
                        acc_n   = '0;
                        found_n = 1'b0;
                    end else begin
                        out_n       = logic_res;
                        zero_n      = (logic_res == '0);
                        out_valid_n = 1'b1;
                    end
                end
            end
            ITER: begin
                acc_n   = acc_step;
                found_n = found_step;
                cnt_n   = cnt_q + CW'(1);
                a_n     = (op_q == OP_CLZ) ? (a_q << CHUNK) : (a_q >> CHUNK);
                if (cnt_q == CW'(N - 1)) begin
                    state_n     = IDLE;
                    out_n       = WIDTH'(acc_step);
                    zero_n      = (acc_step == '0);
                    out_valid_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_POP;
            a_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            found_q   <= 1'b0;
            out       <= '0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_n;
            op_q      <= op_n;
            a_q       <= a_n;
            cnt_q     <= cnt_n;
            acc_q     <= acc_n;
            found_q   <= found_n;
            out       <= out_n;
            zero      <= zero_n;
            out_valid <= out_valid_n;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (32/8 and 16/4 instances).
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [31:0] a, b, res;
    logic [3:0]  func;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_zero, s_busy;
    logic [15:0] s_a, s_b, s_res;
    logic [3:0]  s_func;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .func(func), .out_valid(out_valid), .out_ready(out_ready),
        .out(res), .zero(zero), .busy(busy)
    );

    logic_unit_pipe #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .func(s_func), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out(s_res), .zero(s_zero), .busy(s_busy)
    );

    // Count one comparison and report it if it differs.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue an iterative op on the 32-bit unit and check its fixed 4-cycle latency.
    task automatic run_iter(input string tag, input logic [3:0] f, input logic [31:0] av,
                            input logic [31:0] exp);
        in_valid = 1'b1;
        func     = f;
        a        = av;
        #1;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_stall"}, 32'(in_ready), 32'd0);
            check({tag, "_early"}, 32'(out_valid), 32'd0);
            tick;
        end
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_out"}, res, exp);
        check({tag, "_zero"}, 32'(zero), 32'(exp == 32'd0));
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Same for the 16-bit/4-bit-chunk unit.
    task automatic run_iter16(input string tag, input logic [3:0] f, input logic [15:0] av,
                              input logic [15:0] exp);
        s_in_valid = 1'b1;
        s_func     = f;
        s_a        = av;
        tick;
        s_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy"}, 32'(s_busy), 32'd1);
            check({tag, "_early"}, 32'(s_out_valid), 32'd0);
            tick;
        end
        check({tag, "_vld"}, 32'(s_out_valid), 32'd1);
        check({tag, "_out"}, 32'(s_res), 32'(exp));
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; func = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0; s_func = '0;

        // Reset values
        tick;
        tick;
        check("rst_rdy", 32'(in_ready), 32'd0);
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_out", res, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_rdy", 32'(in_ready), 32'd1);

        // Back-to-back AND then XNOR
        in_valid = 1'b1; func = 4'b0000; a = 32'hF0F0F0F0; b = 32'h0FF00FF0;
        tick;
        check("and_vld", 32'(out_valid), 32'd1);
        check("and_out", res, 32'h00F000F0);
        check("and_zero", 32'(zero), 32'd0);
        check("and_rdy", 32'(in_ready), 32'd1);
        func = 4'b0110;
        tick;
        check("xnor_vld", 32'(out_valid), 32'd1);
        check("xnor_out", res, 32'h00FF00FF);
        check("xnor_zero", 32'(zero), 32'd0);
        check("xnor_rdy", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        tick;
        check("drain_vld", 32'(out_valid), 32'd0);

        // Backpressure: OR 0|0 held for three cycles
        out_ready = 1'b0;
        in_valid = 1'b1; func = 4'b0001; a = '0; b = '0;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_vld", 32'(out_valid), 32'd1);
            check("bp_out", res, 32'd0);
            check("bp_zero", 32'(zero), 32'd1);
            check("bp_rdy", 32'(in_ready), 32'd0);
            tick;
        end
        out_ready = 1'b1;
        in_valid = 1'b1; func = 4'b0100; a = '0;
        #1;
        check("bp_release_rdy", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        check("not_vld", 32'(out_valid), 32'd1);
        check("not_out", res, 32'hFFFFFFFF);
        check("not_zero", 32'(zero), 32'd0);

        // Iterative ops
        run_iter("popcnt", 4'b1000, 32'hFFFF0001, 32'd17);
        run_iter("clz_mid", 4'b1001, 32'h00010000, 32'd15);
        run_iter("clz_zero", 4'b1001, 32'h00000000, 32'd32);
        run_iter("ctz_top", 4'b1010, 32'h80000000, 32'd31);
        run_iter("ctz_zero", 4'b1010, 32'h00000000, 32'd32);

        // Undefined func
        in_valid = 1'b1; func = 4'b1111; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        tick;
        in_valid = 1'b0;
        check("undef_vld", 32'(out_valid), 32'd1);
        check("undef_out", res, 32'd0);
        check("undef_zero", 32'(zero), 32'd1);

        // Reset in the second ITER cycle of a CLZ
        in_valid = 1'b1; func = 4'b1001; a = 32'h00000001;
        tick;
        in_valid = 1'b0;
        check("abort_busy1", 32'(busy), 32'd1);
        tick;
        check("abort_busy2", 32'(busy), 32'd1);
        rst = 1'b1;
        tick;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_vld", 32'(out_valid), 32'd0);
        check("abort_rdy_in_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_rdy", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("abort_no_vld", 32'(out_valid), 32'd0);
            check("abort_idle", 32'(busy), 32'd0);
        end

        // 16-bit / 4-bit-chunk instance
        run_iter16("w16_clz", 4'b1001, 16'h0100, 16'd7);
        run_iter16("w16_pop", 4'b1000, 16'hFFFF, 16'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
